// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: receiver FSM states, the per-frame
// configuration snapshot and the FIFO entry sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_t;

    typedef struct packed {
        logic [3:0] len;
        logic       par_en;
        logic       par_odd;
        logic       stop2;
    } rx_cfg_t;

    // Each FIFO entry carries {break, ferr, perr} above the data bits.
    localparam int FLAG_W = 3;

    function automatic int entry_width(input int data_w);
        return data_w + FLAG_W;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with exact occupancy count.
// A push while full is dropped unless a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; empty gates rdata, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority vote, per-frame latched configuration
// and a FWFT receive FIFO holding per-character error and break flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          baud_os_en,
    input  logic                          rx,
    input  logic [3:0]                    cfg_len,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_odd,
    input  logic                          cfg_stop2,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic                          rd_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic                          rx_busy
);

    localparam int TW      = $clog2(OVERSAMPLE);
    localparam int ENTRY_W = entry_width(DATA_W);

    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    logic              sync1, rx_s;
    rx_state_t         state, next_state;
    rx_cfg_t           cfg_eff, frame;
    logic [TW-1:0]     tick_cnt;
    logic [1:0]        smp;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_acc, perr_r, ferr_r, zero_r;
    logic              start_det, decide, bit_val;
    logic              push, brk_final, ferr_final;
    logic [DATA_W-1:0] push_data;
    logic [ENTRY_W-1:0] push_entry, head;
    logic              fifo_empty, fifo_full;

    // NOTE: sequential blocks use non-blocking assignments so both flops sample the old value on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    always_comb begin
        cfg_eff.len     = (int'(cfg_len) < 5 || int'(cfg_len) > DATA_W) ? 4'(DATA_W) : cfg_len;
        cfg_eff.par_en  = cfg_par_en;
        cfg_eff.par_odd = cfg_par_odd;
        cfg_eff.stop2   = cfg_stop2;
    end

    assign start_det = (state == IDLE) && baud_os_en && !rx_s;
    assign decide    = (state != IDLE) && baud_os_en && (tick_cnt == T_DEC);
    assign bit_val   = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        push       = 1'b0;
        unique case (state)
            IDLE:   if (start_det) next_state = START;
            START:  if (decide) next_state = bit_val ? IDLE : DATA;
            DATA:   if (decide && bit_cnt == frame.len - 4'd1)
                        next_state = frame.par_en ? PARITY : STOP1;
            PARITY: if (decide) next_state = STOP1;
            STOP1:  if (decide) begin
                        if (frame.stop2) begin
                            next_state = STOP2;
                        end else begin
                            next_state = IDLE;
                            push       = 1'b1;
                        end
                    end
            STOP2:  if (decide) begin
                        next_state = IDLE;
                        push       = 1'b1;
                    end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame    <= '0;
            tick_cnt <= '0;
            smp      <= 2'b11;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            zero_r   <= 1'b0;
        end else if (start_det) begin
            frame    <= cfg_eff;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            zero_r   <= 1'b1;
        end else if (state != IDLE && baud_os_en) begin
            tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == T_S0) smp[0] <= rx_s;
            if (tick_cnt == T_S1) smp[1] <= rx_s;
            if (tick_cnt == T_DEC) begin
                case (state)
                    DATA: begin
                        // Bits enter at the MSB; the push right-aligns them to len.
                        shreg   <= {bit_val, shreg[DATA_W-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        par_acc <= par_acc ^ bit_val;
                        zero_r  <= zero_r & ~bit_val;
                    end
                    PARITY: begin
                        perr_r <= (par_acc ^ bit_val) != frame.par_odd;
                        zero_r <= zero_r & ~bit_val;
                    end
                    STOP1: begin
                        ferr_r <= ~bit_val;
                        zero_r <= zero_r & ~bit_val;
                    end
                    default: ;
                endcase
            end
        end
    end

    // At the final stop decision the current sample still has to be folded in.
    assign brk_final  = (state == STOP1) ? (zero_r & ~bit_val) : zero_r;
    assign ferr_final = ferr_r | ~bit_val | brk_final;
    assign push_data  = shreg >> (DATA_W - int'(frame.len));
    assign push_entry = {brk_final, ferr_final, perr_r, push_data};

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (rd_en),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // When full the FIFO is non-empty, so rd_en alone decides whether the push fits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            overflow <= 1'b0;
        else if (push && fifo_full && !rd_en)  overflow <= 1'b1;
        else if (clr_overflow)                 overflow <= 1'b0;
    end

    assign rd_valid = !fifo_empty;
    assign {rd_break, rd_ferr, rd_perr, rd_data} = head;
    assign rx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frame table, multi-cycle
// corner sequences and randomized frames scored against a queue model.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int OS    = 16;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_os_en = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] cfg_len = 4'd8;
    logic       cfg_par_en = 1'b0;
    logic       cfg_par_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       rd_valid, rd_perr, rd_ferr, rd_break, overflow, rx_busy;
    logic [DW-1:0] rd_data;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_checks = 0;
    int n_err    = 0;

    uart_rx_fifo #(.DATA_W(DW), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_os_en   (baud_os_en),
        .rx           (rx),
        .cfg_len      (cfg_len),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_odd  (cfg_par_odd),
        .cfg_stop2    (cfg_stop2),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_perr      (rd_perr),
        .rd_ferr      (rd_ferr),
        .rd_break     (rd_break),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;
    // One-clk oversample tick every second clock, changed away from the active edge.
    always @(negedge clk) baud_os_en = ~baud_os_en;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } ent_t;

    typedef struct {
        logic [3:0] len;
        logic       par_en;
        logic       par_odd;
        logic       stop2;
        logic [7:0] data;
        logic       pb;
        logic       sa;
        logic       sb;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    ent_t mq[$];
    logic ovf_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_os_en) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        wait_ticks(OS);
    endtask

    // Serial frame as seen on the line; optionally pops exactly in the push cycle
    // (final stop decision tick, two ticks of synchroniser delay after mid-bit+1).
    task automatic send_frame(input logic [7:0] data, input int len, input logic par_en,
                              input logic pb, input logic stop2, input logic sa,
                              input logic sb, input bit pop_at_push);
        wait_ticks(1);
        send_bit(1'b0);
        for (int i = 0; i < len; i++) send_bit(data[i]);
        if (par_en) send_bit(pb);
        if (stop2) send_bit(sa);
        @(negedge clk);
        rx = stop2 ? sb : sa;
        if (pop_at_push) begin
            wait_ticks(OS / 2 + 2);
            @(posedge clk);
            @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            wait_ticks(OS / 2 - 3);
        end else begin
            wait_ticks(OS);
        end
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(8);
        @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic check_head(input string name, input ent_t e);
        check({name, ".valid"}, rd_valid, 1);
        check({name, ".data"},  rd_data,  e.data);
        check({name, ".perr"},  rd_perr,  e.perr);
        check({name, ".ferr"},  rd_ferr,  e.ferr);
        check({name, ".break"}, rd_break, e.brk);
    endtask

    function automatic int eff_len(input logic [3:0] l);
        return (l < 5 || l > DW) ? DW : int'(l);
    endfunction

    // Character-level expectation from the frame contents alone.
    function automatic ent_t model_frame(input logic [7:0] data, input int len, input logic par_en,
                                         input logic par_odd, input logic pb, input logic stop2,
                                         input logic sa, input logic sb);
        ent_t e;
        logic [7:0] d;
        d = data & 8'((1 << len) - 1);
        e.data = d;
        e.perr = par_en && ((($countones(d) + int'(pb)) % 2) != int'(par_odd));
        e.brk  = (d == 8'h00) && !(par_en && pb) && !sa;
        e.ferr = !sa || (stop2 && !sb) || e.brk;
        return e;
    endfunction

    initial begin
        vec_t vecs[10];
        ent_t e;

        vecs[0] = '{4'd8, 0, 0, 0, 8'h5A, 0, 1, 1, 8'h5A, 0, 0, 0};
        vecs[1] = '{4'd7, 1, 0, 1, 8'h2A, 0, 1, 1, 8'h2A, 1, 0, 0};
        vecs[2] = '{4'd7, 1, 0, 1, 8'h2B, 0, 1, 1, 8'h2B, 0, 0, 0};
        vecs[3] = '{4'd8, 0, 0, 0, 8'h55, 0, 0, 1, 8'h55, 0, 1, 0};
        vecs[4] = '{4'd8, 0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 1};
        vecs[5] = '{4'd3, 0, 0, 0, 8'hA5, 0, 1, 1, 8'hA5, 0, 0, 0};
        vecs[6] = '{4'd5, 1, 1, 0, 8'h13, 0, 1, 1, 8'h13, 0, 0, 0};
        vecs[7] = '{4'd6, 1, 1, 0, 8'h3F, 0, 1, 1, 8'h3F, 1, 0, 0};
        vecs[8] = '{4'd8, 0, 0, 1, 8'hFF, 0, 1, 0, 8'hFF, 0, 1, 0};
        vecs[9] = '{4'd8, 1, 0, 0, 8'h00, 1, 0, 1, 8'h00, 1, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.valid", rd_valid, 0);
        check("rst.data", rd_data, 0);
        check("rst.perr", rd_perr, 0);
        check("rst.ferr", rd_ferr, 0);
        check("rst.break", rd_break, 0);
        check("rst.count", fifo_count, 0);
        check("rst.overflow", overflow, 0);
        check("rst.busy", rx_busy, 0);
        rst_n = 1'b1;
        wait_ticks(4);

        // Directed frame table
        foreach (vecs[i]) begin
            cfg_len     = vecs[i].len;
            cfg_par_en  = vecs[i].par_en;
            cfg_par_odd = vecs[i].par_odd;
            cfg_stop2   = vecs[i].stop2;
            send_frame(vecs[i].data, eff_len(vecs[i].len), vecs[i].par_en, vecs[i].pb,
                       vecs[i].stop2, vecs[i].sa, vecs[i].sb, 0);
            e = '{vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, vecs[i].exp_brk};
            check_head($sformatf("vec%0d", i), e);
            check($sformatf("vec%0d.count", i), fifo_count, 1);
            check($sformatf("vec%0d.busy", i), rx_busy, 0);
            pop();
            check($sformatf("vec%0d.empty", i), rd_valid, 0);
            check($sformatf("vec%0d.zero", i), rd_data, 0);
        end

        // Start glitch: 6 ticks low is a false start
        cfg_len = 4'd8; cfg_par_en = 0; cfg_stop2 = 0;
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(6);
        @(negedge clk);
        rx = 1'b1;
        check("glitch.busy_hi", rx_busy, 1);
        wait_ticks(20);
        @(negedge clk);
        check("glitch.busy_lo", rx_busy, 0);
        check("glitch.count", fifo_count, 0);

        // Overflow: 9 characters, no reads
        for (int c = 0; c < 9; c++) send_frame(8'(c), 8, 0, 0, 0, 1, 1, 0);
        check("ovf.count", fifo_count, DEPTH);
        check("ovf.flag", overflow, 1);
        check("ovf.head", rd_data, 0);
        @(negedge clk);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("ovf.clear", overflow, 0);
        send_frame(8'h77, 8, 0, 0, 0, 1, 1, 1);
        check("fullpp.count", fifo_count, DEPTH);
        check("fullpp.flag", overflow, 0);
        check("fullpp.head", rd_data, 8'h01);
        for (int c = 1; c < 8; c++) begin
            check($sformatf("drain%0d", c), rd_data, c);
            pop();
        end
        check("drain.last", rd_data, 8'h77);
        pop();
        check("drain.empty", rd_valid, 0);

        // Reset mid-DATA discards the partial frame and the FIFO contents
        send_frame(8'h11, 8, 0, 0, 0, 1, 1, 0);
        wait_ticks(1);
        send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        check("midrst.busy", rx_busy, 1);
        @(negedge clk);
        rx = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.count0", fifo_count, 0);
        check("midrst.busy0", rx_busy, 0);
        rst_n = 1'b1;
        wait_ticks(4);
        send_frame(8'hC3, 8, 0, 0, 0, 1, 1, 0);
        check("midrst.count", fifo_count, 1);
        check("midrst.head", rd_data, 8'hC3);
        pop();

        // cfg_len changed mid-frame does not affect the frame in flight
        fork
            send_frame(8'hA6, 8, 0, 0, 0, 1, 1, 0);
            begin
                wait_ticks(60);
                cfg_len = 4'd5;
            end
        join
        check("cfgchg.head", rd_data, 8'hA6);
        check("cfgchg.count", fifo_count, 1);
        pop();

        // Randomized frames against the queue model
        ovf_exp = 1'b0;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic pe, po, s2, pb, sa, sb;
            int len;
            cfg_len     = 4'($urandom_range(0, 15));
            pe          = 1'($urandom_range(0, 1));
            po          = 1'($urandom_range(0, 1));
            s2          = 1'($urandom_range(0, 1));
            cfg_par_en  = pe;
            cfg_par_odd = po;
            cfg_stop2   = s2;
            len = eff_len(cfg_len);
            d   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            pb  = 1'($urandom_range(0, 1));
            sa  = ($urandom_range(0, 3) != 0);
            sb  = ($urandom_range(0, 3) != 0);
            send_frame(d, len, pe, pb, s2, sa, sb, 0);
            if (mq.size() < DEPTH) mq.push_back(model_frame(d, len, pe, po, pb, s2, sa, sb));
            else ovf_exp = 1'b1;
            check($sformatf("rnd%0d.count", n), fifo_count, mq.size());
            check($sformatf("rnd%0d.ovf", n), overflow, ovf_exp);
            if ($urandom_range(0, 1) == 1) begin
                check_head($sformatf("rnd%0d", n), mq[0]);
                void'(mq.pop_front());
                pop();
            end
        end
        while (mq.size() > 0) begin
            check_head("rnd.drain", mq[0]);
            void'(mq.pop_front());
            pop();
        end
        check("rnd.empty", rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with majority-vote oversampling, runtime frame configuration (5..DATA_W data bits, optional odd/even parity, 1 or 2 stop bits), and a first-word-fall-through receive FIFO that stores per-character error flags. It is the next-generation RX path for the tt_um_uart top level. It replaces the single-register receiver with buffered reception, break detection and sticky overflow reporting. The oversample tick comes from the existing external baud16 generator.

## Interface
Parameters:
- DATA_W, 8, maximum data bits per character (legal 5..9)
- OVERSAMPLE, 16, baud_os_en ticks per bit (even, >= 8)
- FIFO_DEPTH, 8, FIFO entries (power of 2, >= 2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- baud_os_en  in  1  one-clk oversample tick, OVERSAMPLE per bit
- rx  in  1  asynchronous serial input, idle high
- cfg_len  in  4  data bits per char; values <5 or >DATA_W use DATA_W
- cfg_par_en  in  1  parity bit present
- cfg_par_odd  in  1  1 = odd parity, 0 = even
- cfg_stop2  in  1  two stop bits expected
- rd_en  in  1  pop head entry
- rd_valid  out  1  FIFO not empty
- rd_data  out  DATA_W  head character, right-justified, unused MSBs zero
- rd_perr  out  1  head entry parity error
- rd_ferr  out  1  head entry framing error
- rd_break  out  1  head entry is a break
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky: a character was dropped
- clr_overflow  in  1  clears overflow
- rx_busy  out  1  FSM not IDLE

## Operation
- rx passes through a 2-flop synchroniser; both flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. Ticks count only on baud_os_en.
- IDLE: a synced rx=0 on a tick moves to START. Tick counter clears. cfg_* is latched into a frame config register at this point; later cfg changes do not affect the frame in progress.
- Bit value = majority of the 3 samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of the bit period. The decision is made at tick OVERSAMPLE/2+1. Each bit period is OVERSAMPLE ticks.
- START: majority 1 means a false start; return to IDLE with no push.
- DATA: bits arrive LSB first, shifted into bit position [len-1:0]. Move on after len bits.
- PARITY: entered only if par_en. perr = (XOR of data bits ^ parity bit) != par_odd.
- STOP1: ferr = stop sample is 0. With stop2 the FSM goes to STOP2 and ORs that check into ferr.
- Push to the FIFO occurs at the decision tick of the final stop bit, then the FSM goes to IDLE. The FSM does not wait for the stop bit to end, so a start edge in the second half of the stop bit is accepted.
- break = all data bits 0, parity bit 0 (if present), and the first stop sample 0. When break is set, ferr is also set.
- FIFO entry holds {break, ferr, perr, data}.
- Push when full: the new entry is dropped, FIFO contents are unchanged, and overflow is set. A push and a pop in the same cycle when full both succeed.
- rd_en when empty is ignored. Head outputs are zero when empty.
- Overflow: set wins over a clr_overflow in the same cycle.
- Reset values: FSM IDLE, FIFO empty, rd_valid/rd_data/rd_perr/rd_ferr/rd_break/fifo_count/overflow/rx_busy = 0.
- Reset asserted mid-frame aborts the frame; the partial character is discarded.

## Timing
- rx to FSM latency: 2 clk through the synchroniser.
- Push happens in the clk cycle of the final-stop decision tick. rd_valid and fifo_count update on the next clk edge.
- FWFT: rd_data reflects the head entry with no extra cycle. After a pop, the next entry appears the following cycle.
- fifo_count is exact every cycle. A simultaneous push and pop leaves it unchanged.
- rx_busy is high from the START entry cycle through the push cycle, and low the cycle after.

## Structure
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE..STOP2)
  - the cfg struct {len, par_en, par_odd, stop2}
  - the entry-width localparam DATA_W+3
- Sub-module uart_sync_fifo, parametrised by width and depth, provides FWFT, count, full/empty, and push-drop-on-full.
- The FSM, sampler and synchroniser stay in uart_rx_fifo.

## Test plan
- 8N1 at OVERSAMPLE=16, send 0x5A → rd_valid=1, rd_data=0x5A, all flags 0, fifo_count=1. Pop → rd_valid=0.
- 7E2 (cfg_len=7, even), send 0x2A with parity bit 0 → perr=1, data=0x2A. Then send 0x2B with correct parity bit 0 → perr=0.
- 8N1, stop bit driven 0 → ferr=1, break=0 for data 0x55. All-zero line for 10 bits → break=1, ferr=1, data=0.
- Start glitch low for 6 ticks → no push, rx_busy back to 0, fifo_count=0.
- 9 back-to-back chars 0x00..0x08 with no reads at FIFO_DEPTH=8 → count=8, overflow=1, head=0x00, 0x08 absent. clr_overflow → 0. A push with simultaneous pop when full → both succeed.
- Reset asserted mid-DATA, then a clean 0xC3 sent → only 0xC3 is in the FIFO. Changing cfg_len mid-frame does not alter the received character.
